mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter SHALL be TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles spent waiting for dmem_ack before aborting (legal range 1..255).
REQ-002 Port SHALL be clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 Port SHALL be rst_n, input, 1, reset, synchronous and active-low.
REQ-004 Port SHALL be in_valid, input, 1, ALU-stage operation presented.
REQ-005 Port SHALL be in_ready, output, 1, stage can accept an operation this cycle.
REQ-006 Ports SHALL be alu_result / mem_address / store_data, input, 32 each: ALU result, ALU-computed effective address, and rs2 store value.
REQ-007 Ports SHALL be mem_read / mem_write / reg_write, input, 1 each, the ALU control flags.
REQ-008 Port SHALL be rd, input, 5, destination register index.
REQ-009 Ports SHALL be dmem_req / dmem_we, output, 1 each: memory request and write-enable.
REQ-010 Ports SHALL be dmem_addr / dmem_wdata, output, 32 each: memory address and write data.
REQ-011 Ports SHALL be dmem_ack, input, 1, and dmem_rdata, input, 32: access complete, with read data valid on the ack cycle.
REQ-012 Ports SHALL be wb_valid, wb_reg_write, output, 1 each; wb_rd, output, 5; wb_data, output, 32; wb_exc, output, 2 (0 none, 1 misaligned, 2 timeout, 3 read+write conflict).

Function
REQ-013 Handshake: an operation SHALL be accepted on any rising edge where in_valid && in_ready; in_ready = 1 only in state IDLE.
REQ-014 Accepted inputs SHALL be captured into internal registers; inputs SHALL be ignored outside the accept cycle.
REQ-015 FSM states SHALL be IDLE, ACCESS, WB.
REQ-016 From IDLE on accept, the FSM SHALL go to ACCESS when (mem_read xor mem_write) and mem_address[1:0] == 0; otherwise it SHALL go directly to WB.
REQ-017 ACCESS SHALL assert dmem_req = 1, with dmem_addr = captured address, dmem_we = captured mem_write, and dmem_wdata = captured store_data, held stable until exit.
REQ-018 ACCESS SHALL exit to WB on the dmem_ack cycle, latching dmem_rdata for loads.
REQ-019 ACCESS SHALL exit to WB with wb_exc = 2 when TIMEOUT_CYCLES cycles have elapsed in ACCESS without ack; ack arriving on that same cycle SHALL win (no exception).
REQ-020 WB SHALL last exactly one cycle: wb_valid = 1, wb_rd = captured rd, then return to IDLE.
REQ-021 wb_data SHALL be dmem_rdata (load), captured alu_result (non-memory op or store), or 0 on any exception.
REQ-022 wb_reg_write SHALL be captured reg_write for loads and ALU ops, 0 for stores, and 0 whenever wb_exc != 0.
REQ-023 Misaligned address (bits[1:0] != 0) with mem_read or mem_write SHALL issue no dmem_req, and SHALL give wb_exc = 1.
REQ-024 mem_read and mem_write both 1 SHALL issue no dmem_req, and SHALL give wb_exc = 3; the conflict check takes priority over the misaligned check.
REQ-025 Latency SHALL be: non-memory op accepted at cycle N gives wb_valid at N+1; memory op accepted at N gives dmem_req from N+1 and wb_valid at ack_cycle+1.
REQ-026 Throughput SHALL be one operation per two cycles minimum; no overlap, one outstanding access.
REQ-027 Outside ACCESS, dmem_req and dmem_we SHALL be 0; outside WB, wb_valid and wb_reg_write SHALL be 0.

Reset
REQ-028 rst_n = 0 at a rising edge SHALL force state IDLE, timeout counter 0, and all outputs 0 except in_ready = 1 on the following cycle.
REQ-029 Reset during ACCESS SHALL drop dmem_req on the next edge, produce no wb_valid, and discard any later ack until a new request.

Structure
REQ-030 State encoding, wb_exc codes and the 2-bit alignment mask SHALL live in shared package riscv_pkg.
REQ-031 The timeout counter SHALL be sub-module mem_timeout_counter (clear, enable, expired), sized to $clog2(TIMEOUT_CYCLES+1) bits.

Verification
REQ-032 ALU op: alu_result = 0x0000_0005, reg_write = 1, rd = 3 -> next cycle wb_valid = 1, wb_data = 5, wb_rd = 3, no dmem_req.
REQ-033 Load: addr 0x100, ack after 3 cycles with rdata 0xDEAD_BEEF -> dmem_req for 3 cycles, wb_data = 0xDEAD_BEEF, wb_reg_write = 1.
REQ-034 Store: addr 0x104, store_data 0x1234 -> dmem_we = 1, dmem_wdata = 0x1234, wb_reg_write = 0, wb_exc = 0.
REQ-035 Load at 0x102 -> no dmem_req, wb_exc = 1, wb_reg_write = 0; read+write both set -> wb_exc = 3.
REQ-036 Load with ack never asserted -> dmem_req high exactly 16 cycles, then wb_exc = 2.
REQ-037 Reset asserted in second ACCESS cycle -> dmem_req 0 after edge, no wb_valid, in_ready = 1 after rst_n release.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================
// riscv_pkg : shared types for the memory-access pipeline stage
// Revision: 1.0
// ============================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        EXC_NONE       = 2'd0,
        EXC_MISALIGNED = 2'd1,
        EXC_TIMEOUT    = 2'd2,
        EXC_CONFLICT   = 2'd3
    } mem_exc_e;

    localparam logic [1:0] c_align_mask = 2'b11;

    // Exception known at accept time; a simultaneous read+write outranks misalignment.
    function automatic mem_exc_e decode_exc(
        input logic       rd,
        input logic       wr,
        input logic [1:0] addr_lo
    );
        mem_exc_e exc;
        exc = EXC_NONE;
        if (rd && wr) begin
            exc = EXC_CONFLICT;
        end else if ((rd || wr) && ((addr_lo & c_align_mask) != 2'b00)) begin
            exc = EXC_MISALIGNED;
        end
        return exc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_timeout_counter.sv
// ============================================================
// mem_timeout_counter : counts cycles spent waiting for a memory ack
// Revision: 1.0
// ============================================================
`default_nettype none

module mem_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;

    // count_q holds the number of completed waiting cycles, so the flag
    // rises during the LIMIT-th cycle and the caller can leave at its end.
    assign expired_o = (count_q == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expired_o) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================
// mem_access_stage : single-outstanding load/store stage feeding writeback
// Revision: 1.0
// ============================================================
`default_nettype none

module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_address,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic [4:0]  rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_exc
);

    mem_state_e  state_q, state_d;
    mem_exc_e    exc_q, exc_d;
    logic [31:0] addr_q, wdata_q, alu_q, rdata_q;
    logic [4:0]  rd_q;
    logic        load_q, store_q, reg_write_q;

    logic w_accept, w_is_mem, w_expired, w_in_access, w_in_wb, w_ok;

    assign in_ready    = (state_q == ST_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mem    = mem_read || mem_write;
    assign w_in_access = (state_q == ST_ACCESS);
    assign w_in_wb     = (state_q == ST_WB);
    assign w_ok        = (exc_q == EXC_NONE);

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    exc_d   = decode_exc(mem_read, mem_write, mem_address[1:0]);
                    state_d = (w_is_mem && (exc_d == EXC_NONE)) ? ST_ACCESS : ST_WB;
                end
            end
            ST_ACCESS: begin
                // An ack in the final waiting cycle takes precedence over the timeout.
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (w_expired) begin
                    state_d = ST_WB;
                    exc_d   = EXC_TIMEOUT;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            exc_q   <= EXC_NONE;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            rd_q        <= '0;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            if (w_accept) begin
                addr_q      <= mem_address;
                wdata_q     <= store_data;
                alu_q       <= alu_result;
                rd_q        <= rd;
                load_q      <= mem_read;
                store_q     <= mem_write;
                reg_write_q <= reg_write;
            end
            if (w_in_access && dmem_ack && load_q) begin
                rdata_q <= dmem_rdata;
            end
        end
    end

    mem_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (!w_in_access),
        .enable_i  (w_in_access),
        .expired_o (w_expired)
    );

    assign dmem_req     = w_in_access;
    assign dmem_we      = w_in_access && store_q;
    assign dmem_addr    = w_in_access ? addr_q  : '0;
    assign dmem_wdata   = w_in_access ? wdata_q : '0;

    assign wb_valid     = w_in_wb;
    assign wb_rd        = w_in_wb ? rd_q : '0;
    assign wb_exc       = w_in_wb ? exc_q : EXC_NONE;
    assign wb_data      = (w_in_wb && w_ok) ? (load_q ? rdata_q : alu_q) : '0;
    assign wb_reg_write = w_in_wb && w_ok && !store_q && reg_write_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================
// tb_mem_access_stage : randomized scoreboard bench for mem_access_stage
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_mem_access_stage;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result = '0, mem_address = '0, store_data = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
    logic [4:0]  rd = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .mem_address  (mem_address),
        .store_data   (store_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .rd           (rd),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_exc       (wb_exc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  exc;
        logic        rw;
        int          wb_cyc;
        int          nreq;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        acc_exp = 1'b0;
    logic        acc_we = 1'b0;
    logic [31:0] acc_addr = '0, acc_wdata = '0;
    int          req_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: checks memory-side activity and pops the scoreboard on every writeback.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            req_cnt = 0;
        end else begin
            if (dmem_req) begin
                if (!acc_exp) begin
                    check("unexpected_req", 32'(dmem_req), 32'd0);
                end else begin
                    check("dmem_addr", dmem_addr, acc_addr);
                    check("dmem_we", 32'(dmem_we), 32'(acc_we));
                    check("dmem_wdata", dmem_wdata, acc_wdata);
                end
                req_cnt++;
            end else if (dmem_we) begin
                check("we_outside_access", 32'(dmem_we), 32'd0);
            end
            if (wb_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_wb", 32'(wb_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                    check("wb_data", wb_data, e.data);
                    check("wb_exc", 32'(wb_exc), 32'(e.exc));
                    check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                    check("wb_cycle", 32'(cyc), 32'(e.wb_cyc));
                    check("req_cycles", 32'(req_cnt), 32'(e.nreq));
                end
                req_cnt = 0;
            end else if (wb_reg_write) begin
                check("rw_outside_wb", 32'(wb_reg_write), 32'd0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 once the operation's memory phase is over.
    task automatic issue(input logic rd_f, input logic wr_f, input logic rw,
                         input logic [4:0] rdi, input logic [31:0] alu,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input int delay, input logic [31:0] rdata);
        exp_t e;
        logic access;
        int   nreq;
        int   waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_wait", 32'(in_ready), 32'd1);
            return;
        end
        access = 1'b0;
        nreq   = 0;
        e.rd   = rdi;
        if (rd_f && wr_f) begin
            e.exc = 2'd3;
        end else if ((rd_f || wr_f) && (addr % 4 != 0)) begin
            e.exc = 2'd1;
        end else if (rd_f || wr_f) begin
            access = 1'b1;
            nreq   = (delay <= T) ? delay : T;
            e.exc  = (delay <= T) ? 2'd0 : 2'd2;
        end else begin
            e.exc = 2'd0;
        end
        e.data   = (e.exc != 2'd0) ? 32'd0 : (rd_f ? rdata : alu);
        e.rw     = (e.exc == 2'd0) && !wr_f && rw;
        e.nreq   = nreq;
        e.wb_cyc = cyc + 1 + nreq;

        in_valid    = 1'b1;
        mem_read    = rd_f;
        mem_write   = wr_f;
        reg_write   = rw;
        rd          = rdi;
        alu_result  = alu;
        mem_address = addr;
        store_data  = sd;
        acc_exp     = access;
        acc_addr    = addr;
        acc_we      = wr_f;
        acc_wdata   = sd;
        sb.push_back(e);

        @(posedge clk); #1;
        in_valid    = 1'b0;
        mem_read    = 1'($urandom);
        mem_write   = 1'($urandom);
        reg_write   = 1'($urandom);
        rd          = 5'($urandom);
        alu_result  = $urandom;
        mem_address = $urandom;
        store_data  = $urandom;
        if (access) begin
            for (int k = 1; k <= nreq; k++) begin
                dmem_ack   = (k == delay);
                dmem_rdata = (k == delay) ? rdata : $urandom;
                if (k < nreq) begin
                    @(posedge clk); #1;
                end
            end
            @(posedge clk); #1;
            acc_exp = 1'b0;
        end
        dmem_ack   = 1'($urandom);
        dmem_rdata = $urandom;
    endtask

    task automatic reset_during_access();
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        in_valid    = 1'b1;
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        reg_write   = 1'b1;
        rd          = 5'd12;
        mem_address = 32'h0000_0200;
        acc_exp     = 1'b1;
        acc_addr    = 32'h0000_0200;
        acc_we      = 1'b0;
        acc_wdata   = store_data;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        acc_exp = 1'b0;
        @(negedge clk);
        check("rst_drops_req", 32'(dmem_req), 32'd0);
        check("rst_no_wb", 32'(wb_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        repeat (3) begin
            @(negedge clk);
            check("late_ack_ignored_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] a;
        int          kind;
        logic        r, w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_rw", 32'(wb_reg_write), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_exc", 32'(wb_exc), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0005, 32'h0000_0013, 32'h0, 1, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 5'd7, 32'h1111_1111, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
        issue(1'b0, 1'b1, 1'b1, 5'd9, 32'h2222_2222, 32'h0000_0104, 32'h0000_1234, 2, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 5'd4, 32'h3333_3333, 32'h0000_0102, 32'h0, 1, 32'h0);
        issue(1'b1, 1'b1, 1'b1, 5'd5, 32'h4444_4444, 32'h0000_0100, 32'h0, 1, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 5'd6, 32'h5555_5555, 32'h0000_0108, 32'h0, 1000, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 5'd8, 32'h6666_6666, 32'h0000_010C, 32'h0, T, 32'hCAFE_F00D);
        issue(1'b0, 1'b1, 1'b0, 5'd2, 32'h7777_7777, 32'h0000_0110, 32'hABCD, T + 1, 32'h0);

        reset_during_access();

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 4);
            a    = $urandom;
            r    = 1'b0;
            w    = 1'b0;
            case (kind)
                0: begin r = 1'b0; w = 1'b0; end
                1: begin r = 1'b1; a[1:0] = 2'b00; end
                2: begin w = 1'b1; a[1:0] = 2'b00; end
                3: begin
                    r = 1'($urandom);
                    w = !r;
                    a[1:0] = 2'($urandom_range(1, 3));
                end
                default: begin r = 1'b1; w = 1'b1; end
            endcase
            issue(r, w, 1'($urandom), 5'($urandom), $urandom, a, $urandom,
                  $urandom_range(1, T + 2), $urandom);
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
